// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared widths, home values, sequencer states and gap helper
package arm_pkg;

    localparam int DUTY_W    = 20;
    localparam int GAP_W     = 12;
    localparam int HOME_DUTY = 75_000;
    localparam int HOME_GAP  = 1000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MOVE,
        ST_DWELL
    } state_t;

    // A zero step gap would stall the ramp, so it is presented as the fastest legal gap.
    function automatic logic [GAP_W-1:0] gap_floor(input logic [GAP_W-1:0] g);
        return (g == '0) ? {{(GAP_W-1){1'b0}}, 1'b1} : g;
    endfunction

endpackage

// File: rtl/arm_pose_sequencer_pose_table.sv
// rtl/arm_pose_sequencer_pose_table.sv - pose RAM with per-channel write and registered read
module pose_table
    import arm_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int NPOSE = 8,
    parameter int PW    = 3,
    parameter int CW    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_duty_en,
    input  logic                    wr_gap_en,
    input  logic [PW-1:0]           wr_pose,
    input  logic [CW-1:0]           wr_ch,
    input  logic [DUTY_W-1:0]       wr_duty,
    input  logic [GAP_W-1:0]        wr_gap,
    input  logic                    rd_en,
    input  logic [PW-1:0]           rd_pose,
    output logic [NCH*DUTY_W-1:0]   rd_duty,
    output logic [GAP_W-1:0]        rd_gap
);

    localparam int EW = NCH * DUTY_W + GAP_W;

    logic [EW-1:0] mem [NPOSE];
    logic [EW-1:0] rd_q;
    logic [EW-1:0] rd_d;
    logic          wr_ok;

    assign wr_ok = (int'(wr_pose) < NPOSE);

    // Table writes land in one channel slice or the gap slice; contents are never reset.
    always_ff @(posedge clk) begin
        if (wr_ok && wr_duty_en) begin
            mem[wr_pose][int'(wr_ch)*DUTY_W +: DUTY_W] <= wr_duty;
        end
        if (wr_ok && wr_gap_en) begin
            mem[wr_pose][NCH*DUTY_W +: GAP_W] <= wr_gap;
        end
    end

    // Read data only changes when a read is issued; a same-cycle write is not seen.
    always_comb begin
        rd_d = rd_q;
        if (rd_en) begin
            rd_d = mem[rd_pose];
        end
    end

    // Registered read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    assign rd_duty = rd_q[NCH*DUTY_W-1:0];
    assign rd_gap  = rd_q[EW-1 -: GAP_W];

endmodule

// File: rtl/arm_pose_sequencer.sv
// rtl/arm_pose_sequencer.sv - steps the set_duty ramps through a stored pose list
module arm_pose_sequencer
    import arm_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int NPOSE   = 8,
    parameter int DWELL_W = 26,
    localparam int PW     = $clog2(NPOSE),
    localparam int CW     = $clog2(NCH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tbl_duty_we,
    input  logic                    tbl_gap_we,
    input  logic [PW-1:0]           tbl_pose,
    input  logic [CW-1:0]           tbl_ch,
    input  logic [DUTY_W-1:0]       tbl_duty,
    input  logic [GAP_W-1:0]        tbl_gap,
    input  logic                    start,
    input  logic                    stop,
    input  logic [PW:0]             pose_count,
    input  logic                    loop_en,
    input  logic [DWELL_W-1:0]      dwell_cycles,
    input  logic [NCH*DUTY_W-1:0]   duty_fb,
    output logic [NCH*DUTY_W-1:0]   duty_need,
    output logic [GAP_W-1:0]        duty_gap,
    output logic                    busy,
    output logic                    done,
    output logic [PW-1:0]           cur_pose
);

    localparam logic [PW:0]        NPOSE_N = (PW+1)'(NPOSE);
    localparam logic [PW:0]        ONE_N   = (PW+1)'(1);
    localparam logic [PW-1:0]      ONE_P   = PW'(1);
    localparam logic [DWELL_W-1:0] ONE_D   = DWELL_W'(1);

    state_t                 state_q,     state_d;
    logic [PW-1:0]          cur_pose_q,  cur_pose_d;
    logic [PW:0]            n_q,         n_d;
    logic                   loop_q,      loop_d;
    logic [DWELL_W-1:0]     dwell_lat_q, dwell_lat_d;
    logic [DWELL_W-1:0]     dwell_cnt_q, dwell_cnt_d;
    logic [NCH*DUTY_W-1:0]  duty_need_q, duty_need_d;
    logic [GAP_W-1:0]       duty_gap_q,  duty_gap_d;
    logic                   done_q,      done_d;

    logic                   rd_en;
    logic [NCH*DUTY_W-1:0]  rd_duty;
    logic [GAP_W-1:0]       rd_gap;
    logic                   arrived;
    logic                   last_pose;

    // The table read is issued on the edge that enters LOAD, addressed by the pose being loaded.
    assign rd_en = (state_d == ST_LOAD);

    pose_table #(
        .NCH   (NCH),
        .NPOSE (NPOSE),
        .PW    (PW),
        .CW    (CW)
    ) u_pose_table (
        .clk        (clk),
        .rst        (rst),
        .wr_duty_en (tbl_duty_we),
        .wr_gap_en  (tbl_gap_we),
        .wr_pose    (tbl_pose),
        .wr_ch      (tbl_ch),
        .wr_duty    (tbl_duty),
        .wr_gap     (tbl_gap),
        .rd_en      (rd_en),
        .rd_pose    (cur_pose_d),
        .rd_duty    (rd_duty),
        .rd_gap     (rd_gap)
    );

    // Arrival means every ramp output exactly equals its target.
    always_comb begin
        arrived = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            if (duty_fb[c*DUTY_W +: DUTY_W] != duty_need_q[c*DUTY_W +: DUTY_W]) begin
                arrived = 1'b0;
            end
        end
    end

    assign last_pose = ({1'b0, cur_pose_q} == (n_q - ONE_N));

    // Next-state and datapath updates; stop from any busy state freezes the arm where it is.
    always_comb begin
        state_d     = state_q;
        cur_pose_d  = cur_pose_q;
        n_d         = n_q;
        loop_d      = loop_q;
        dwell_lat_d = dwell_lat_q;
        dwell_cnt_d = dwell_cnt_q;
        duty_need_d = duty_need_q;
        duty_gap_d  = duty_gap_q;
        done_d      = 1'b0;

        if (stop && (state_q != ST_IDLE)) begin
            duty_need_d = duty_fb;
            state_d     = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !stop && (pose_count != '0)) begin
                        state_d    = ST_LOAD;
                        cur_pose_d = '0;
                        n_d        = (pose_count > NPOSE_N) ? NPOSE_N : pose_count;
                        loop_d     = loop_en;
                    end
                end
                ST_LOAD: begin
                    state_d     = ST_MOVE;
                    duty_need_d = rd_duty;
                    duty_gap_d  = gap_floor(rd_gap);
                    dwell_lat_d = dwell_cycles;
                end
                ST_MOVE: begin
                    if (arrived) begin
                        state_d     = ST_DWELL;
                        dwell_cnt_d = '0;
                    end
                end
                ST_DWELL: begin
                    if (dwell_cnt_q == dwell_lat_q) begin
                        if (!last_pose) begin
                            cur_pose_d = cur_pose_q + ONE_P;
                            state_d    = ST_LOAD;
                        end else if (loop_q) begin
                            cur_pose_d = '0;
                            state_d    = ST_LOAD;
                        end else begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        dwell_cnt_d = dwell_cnt_q + ONE_D;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and output registers; reset parks every channel at the home position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cur_pose_q  <= '0;
            n_q         <= '0;
            loop_q      <= 1'b0;
            dwell_lat_q <= '0;
            dwell_cnt_q <= '0;
            duty_need_q <= {NCH{DUTY_W'(HOME_DUTY)}};
            duty_gap_q  <= GAP_W'(HOME_GAP);
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_pose_q  <= cur_pose_d;
            n_q         <= n_d;
            loop_q      <= loop_d;
            dwell_lat_q <= dwell_lat_d;
            dwell_cnt_q <= dwell_cnt_d;
            duty_need_q <= duty_need_d;
            duty_gap_q  <= duty_gap_d;
            done_q      <= done_d;
        end
    end

    assign duty_need = duty_need_q;
    assign duty_gap  = duty_gap_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign cur_pose  = cur_pose_q;

endmodule

// File: tb/tb_arm_pose_sequencer.sv
// tb/tb_arm_pose_sequencer.sv - directed bench with ramp models on every channel
module tb_arm_pose_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tbl_duty_we = 1'b0;
    logic        tbl_gap_we = 1'b0;
    logic [2:0]  tbl_pose = '0;
    logic [1:0]  tbl_ch = '0;
    logic [19:0] tbl_duty = '0;
    logic [11:0] tbl_gap = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [3:0]  pose_count = '0;
    logic        loop_en = 1'b0;
    logic [25:0] dwell_cycles = '0;
    logic [79:0] duty_fb;
    logic [79:0] duty_need;
    logic [11:0] duty_gap;
    logic        busy;
    logic        done;
    logic [2:0]  cur_pose;

    int tests = 0;
    int fails = 0;

    logic [19:0] m_out [4];
    int          m_cnt [4];

    int done_cnt = 0;
    int last_pose = -1;
    int log_q [$];

    always #10 clk = ~clk;

    arm_pose_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .tbl_duty_we  (tbl_duty_we),
        .tbl_gap_we   (tbl_gap_we),
        .tbl_pose     (tbl_pose),
        .tbl_ch       (tbl_ch),
        .tbl_duty     (tbl_duty),
        .tbl_gap      (tbl_gap),
        .start        (start),
        .stop         (stop),
        .pose_count   (pose_count),
        .loop_en      (loop_en),
        .dwell_cycles (dwell_cycles),
        .duty_fb      (duty_fb),
        .duty_need    (duty_need),
        .duty_gap     (duty_gap),
        .busy         (busy),
        .done         (done),
        .cur_pose     (cur_pose)
    );

    // set_duty stand-in: one LSB toward the target every duty_gap cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < 4; c++) begin
                m_out[c] <= 20'd75000;
                m_cnt[c] <= 0;
            end
        end else begin
            for (int c = 0; c < 4; c++) begin
                if (m_out[c] == duty_need[c*20 +: 20]) begin
                    m_cnt[c] <= 0;
                end else if (m_cnt[c] >= int'(duty_gap) - 1) begin
                    m_cnt[c] <= 0;
                    m_out[c] <= (m_out[c] < duty_need[c*20 +: 20]) ? m_out[c] + 20'd1 : m_out[c] - 20'd1;
                end else begin
                    m_cnt[c] <= m_cnt[c] + 1;
                end
            end
        end
    end

    assign duty_fb = {m_out[3], m_out[2], m_out[1], m_out[0]};

    // Record done pulses and every change of the loaded pose.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) done_cnt++;
            if (int'(cur_pose) != last_pose) begin
                log_q.push_back(int'(cur_pose));
                last_pose = int'(cur_pose);
            end
        end
    end

    function automatic logic [79:0] pack(input int a0, input int a1, input int a2, input int a3);
        return {20'(a3), 20'(a2), 20'(a1), 20'(a0)};
    endfunction

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr_duty(input int p, input int ch, input int v);
        tbl_pose = 3'(p); tbl_ch = 2'(ch); tbl_duty = 20'(v); tbl_duty_we = 1'b1;
        tick();
        tbl_duty_we = 1'b0;
    endtask

    task automatic wr_gap(input int p, input int g);
        tbl_pose = 3'(p); tbl_gap = 12'(g); tbl_gap_we = 1'b1;
        tick();
        tbl_gap_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_pose(input int p, input string tag);
        int n = 0;
        while (int'(cur_pose) != p && n < 3000) begin
            tick();
            n++;
        end
        check(tag, 80'(cur_pose), 80'(p));
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 3000) begin
            tick();
            n++;
        end
        check(tag, 80'(done), 80'(1));
    endtask

    task automatic clear_log();
        log_q.delete();
        last_pose = -1;
    endtask

    logic [79:0] home_v;
    logic [79:0] cap;
    int          hold;
    int          n;

    initial begin
        home_v = pack(75000, 75000, 75000, 75000);
        @(negedge clk);
        tick();
        tick();
        check("reset_need", duty_need, home_v);
        check("reset_gap",  80'(duty_gap), 80'(1000));
        check("reset_busy", 80'(busy), 80'(0));
        check("reset_done", 80'(done), 80'(0));
        check("reset_pose", 80'(cur_pose), 80'(0));
        rst = 1'b0;
        tick();

        // Pose table: pose0 ch0 10 LSB high, pose1 home, pose2 ch1 +4 with gap 0.
        for (int c = 0; c < 4; c++) begin
            wr_duty(0, c, (c == 0) ? 75010 : 75000);
            wr_duty(1, c, 75000);
            wr_duty(2, c, (c == 1) ? 75004 : 75000);
        end
        wr_gap(0, 2);
        wr_gap(1, 2);
        wr_gap(2, 0);

        // Two-pose single run with dwell 10.
        pose_count = 4'd2; loop_en = 1'b0; dwell_cycles = 26'd10;
        done_cnt = 0;
        pulse_start();
        check("load_busy", 80'(busy), 80'(1));
        check("load_need_old", duty_need, home_v);
        tick();
        check("move_need", duty_need, pack(75010, 75000, 75000, 75000));
        check("move_gap", 80'(duty_gap), 80'(2));
        hold = 0;
        n = 0;
        while (done !== 1'b1 && n < 3000) begin
            if (busy && cur_pose == 3'd0 && duty_fb[19:0] == 20'd75010) hold++;
            tick();
            n++;
        end
        check("run1_done", 80'(done), 80'(1));
        check("run1_hold", 80'(hold), 80'(12));
        check("run1_need", duty_need, home_v);
        check("run1_pose", 80'(cur_pose), 80'(1));
        check("run1_idle", 80'(busy), 80'(0));
        tick();
        check("run1_done_pulse", 80'(done), 80'(0));
        check("run1_done_cnt", 80'(done_cnt), 80'(1));

        // Looping three-pose run with dwell 0.
        pose_count = 4'd3; loop_en = 1'b1; dwell_cycles = 26'd0;
        done_cnt = 0;
        pulse_start();
        clear_log();
        wait_pose(1, "loop_p1");
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_in_move_pose", 80'(cur_pose), 80'(1));
        check("start_in_move_busy", 80'(busy), 80'(1));
        wr_duty(1, 2, 75003);
        check("write_loaded_pose", duty_need, home_v);
        wait_pose(2, "loop_p2");
        tick();
        check("gap0_as_1", 80'(duty_gap), 80'(1));
        check("pose2_need", duty_need, pack(75000, 75004, 75000, 75000));
        wait_pose(0, "loop_wrap");
        wait_pose(1, "loop_p1b");
        tick();
        check("reload_new_entry", duty_need, pack(75000, 75000, 75003, 75000));
        wait_pose(2, "loop_p2b");
        wait_pose(0, "loop_wrap2");
        tick();
        for (int i = 0; i < 5; i++) tick();
        cap = duty_fb;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_need", duty_need, cap);
        check("stop_idle", 80'(busy), 80'(0));
        check("stop_gap_held", 80'(duty_gap), 80'(2));
        check("stop_pose", 80'(cur_pose), 80'(0));
        check("loop_no_done", 80'(done_cnt), 80'(0));
        check("loop_seq_len", 80'(log_q.size()), 80'(7));
        for (int i = 0; i < 7 && i < log_q.size(); i++) begin
            check($sformatf("loop_seq_%0d", i), 80'(log_q[i]), 80'(i % 3));
        end

        // Ignored starts.
        pose_count = 4'd0;
        pulse_start();
        check("count0_busy", 80'(busy), 80'(0));
        tick();
        check("count0_done", 80'(done_cnt), 80'(0));
        pose_count = 4'd2;
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("start_stop_busy", 80'(busy), 80'(0));
        check("start_stop_need", duty_need, cap);

        // pose_count beyond the table depth runs every pose once.
        for (int p = 2; p < 8; p++) begin
            for (int c = 0; c < 4; c++) wr_duty(p, c, 75000);
            wr_gap(p, 1);
        end
        pose_count = 4'd15; loop_en = 1'b0; dwell_cycles = 26'd0;
        done_cnt = 0;
        pulse_start();
        clear_log();
        wait_done("full_done");
        tick();
        check("full_done_cnt", 80'(done_cnt), 80'(1));
        check("full_pose", 80'(cur_pose), 80'(7));
        check("full_seq_len", 80'(log_q.size()), 80'(8));
        for (int i = 0; i < 8 && i < log_q.size(); i++) begin
            check($sformatf("full_seq_%0d", i), 80'(log_q[i]), 80'(i));
        end

        // Asynchronous reset in the middle of a move.
        pose_count = 4'd1;
        pulse_start();
        tick();
        tick();
        tick();
        check("pre_reset_busy", 80'(busy), 80'(1));
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 80'(busy), 80'(0));
        check("arst_need", duty_need, home_v);
        check("arst_gap",  80'(duty_gap), 80'(1000));
        check("arst_pose", 80'(cur_pose), 80'(0));
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("post_reset_idle", 80'(busy), 80'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
